// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the serial word receiver.
// Imported by the shift core and the output-buffer top level.
package sipo_rx_pkg;

    typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;

    // Counter width able to hold 0..width.
    function automatic int count_w(input int width);
        return $clog2(width + 32'sd1);
    endfunction

endpackage

// File: rtl/sipo_word_receiver_if.sv
// Word-level valid/ready handshake between the receiver and its consumer.
interface sipo_word_receiver_if #(parameter int WIDTH = 32'sd4);
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;

    modport master (output word_out, output word_valid, input word_ready);
    modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter: assembles serial bits into words and
// pulses done in the cycle the final bit of a word is sampled.
module sipo_shift_core
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = 32'sd4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        frame_start,
    input  logic                        bit_valid,
    input  logic                        bit_in,
    output logic [WIDTH-1:0]            word,
    output logic                        done,
    output logic [count_w(WIDTH)-1:0]   bit_count
);
    localparam int CW = count_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 32'sd1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(32'sd1);

    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] shift_s;
    logic [CW-1:0]    cnt_base_s;
    logic [CW-1:0]    cnt_next_s;
    logic             done_s;

    // Next shift/count state; frame_start realigns before the new bit is taken.
    always_comb begin
        base_s     = shreg_r;
        cnt_base_s = count_r;
        shift_s    = shreg_r;
        cnt_next_s = count_r;
        done_s     = 1'b0;
        if (frame_start) begin
            base_s     = {WIDTH{1'b0}};
            cnt_base_s = {CW{1'b0}};
        end else begin
            base_s     = shreg_r;
            cnt_base_s = count_r;
        end
        if (bit_valid) begin
            if (LSB_FIRST) begin
                shift_s = {bit_in, base_s[WIDTH-1:1]};
            end else begin
                shift_s = {base_s[WIDTH-2:0], bit_in};
            end
            if (cnt_base_s == LAST_CNT) begin
                cnt_next_s = {CW{1'b0}};
                done_s     = 1'b1;
            end else begin
                cnt_next_s = cnt_base_s + ONE_CNT;
                done_s     = 1'b0;
            end
        end else begin
            shift_s    = base_s;
            cnt_next_s = cnt_base_s;
            done_s     = 1'b0;
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            shreg_r <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            shreg_r <= shift_s;
            count_r <= cnt_next_s;
        end
    end

    assign word      = shift_s;
    assign done      = done_s;
    assign bit_count = count_r;

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver: one-entry output buffer with
// valid/ready handshake and a sticky overflow flag for dropped words.
module sipo_word_receiver
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = 32'sd4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        frame_start,
    input  logic                        bit_valid,
    input  logic                        bit_in,
    sipo_word_receiver_if.master        bus,
    output logic                        overflow,
    output logic [count_w(WIDTH)-1:0]   bit_count
);
    logic [WIDTH-1:0] word_s;
    logic             done_s;
    buf_state_t       state_r;
    logic [WIDTH-1:0] word_r;
    logic             valid_r;
    logic             overflow_r;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .word        (word_s),
        .done        (done_s),
        .bit_count   (bit_count)
    );

    // Output buffer FSM; a completion while full and stalled is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= BUF_EMPTY;
            word_r     <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (clear) begin
            state_r    <= BUF_EMPTY;
            word_r     <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (done_s) begin
                        state_r <= BUF_FULL;
                        word_r  <= word_s;
                        valid_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                BUF_FULL: begin
                    if (done_s && bus.word_ready) begin
                        word_r  <= word_s;
                        valid_r <= 1'b1;
                    end else if (done_s) begin
                        overflow_r <= 1'b1;
                        valid_r    <= 1'b1;
                    end else if (bus.word_ready) begin
                        state_r <= BUF_EMPTY;
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= BUF_EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_out   = word_r;
    assign bus.word_valid = valid_r;
    assign overflow       = overflow_r;

endmodule
